key_debouncer: RTL and testbench

- Conditions one raw, active-low pushbutton into a clean, glitch-free, active-low level for the game-of-life front end.
- Sits between the board pin and the key-pulse stage. Its `KEY` output is the stabilized input that stage turns into one-cycle pulses.
- Synchronizes the asynchronous pin, then requires the new level to stay steady for a programmable number of cycles before passing it on.
- Flags each accepted change with a one-cycle event strobe.

---
 rtl/key_debounce_pkg.sv | 9 +
 rtl/sync_chain.sv | 22 ++
 rtl/key_debouncer.sv | 82 ++++++++
 tb/tb_key_debouncer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {S_UP, S_CHK_DN, S_DN, S_CHK_UP} state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/sync_chain.sv
// Parameterized-depth 1-bit synchronizer; resets to 1 (released button level).
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Debounces one active-low pushbutton: synchronize, then demand N+1 steady
// samples before the clean level moves; each accepted change pulses KEY_changed.
module key_debouncer
  import key_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic KEY_raw,
  output logic KEY,
  output logic KEY_changed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_q, key_d;
  logic          chg_q, chg_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .din  (KEY_raw),
    .dout (key_s)
  );

  // Counter only leaves CHECK at CNT_MAX, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
    case (state_q)
      S_UP: if (!key_s) begin
        state_d = S_CHK_DN;
        cnt_d   = '0;
      end
      S_CHK_DN: begin
        if (key_s)                state_d = S_UP;
        else if (cnt_q == CNT_MAX) begin
          state_d = S_DN;
          chg_d   = 1'b1;
        end else                  cnt_d = cnt_q + 1'b1;
      end
      S_DN: if (key_s) begin
        state_d = S_CHK_UP;
        cnt_d   = '0;
      end
      S_CHK_UP: begin
        if (!key_s)               state_d = S_DN;
        else if (cnt_q == CNT_MAX) begin
          state_d = S_UP;
          chg_d   = 1'b1;
        end else                  cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_UP;
    endcase
    key_d = (state_d == S_UP) || (state_d == S_CHK_DN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_UP;
      cnt_q   <= '0;
      key_q   <= 1'b1;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      chg_q   <= chg_d;
    end
  end

  assign KEY         = key_q;
  assign KEY_changed = chg_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer at SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (7-edge latency).
module tb_key_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic KEY_raw;
  logic KEY;
  logic KEY_changed;

  int checks = 0;
  int errors = 0;

  key_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .KEY_raw    (KEY_raw),
    .KEY        (KEY),
    .KEY_changed(KEY_changed)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic lvl, input int n);
    KEY_raw = lvl;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    KEY_raw = 1'b0;
    repeat (3) tick();
    checks++;
    if (KEY !== 1'b1 || KEY_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold KEY=%b chg=%b want KEY=1 chg=0", KEY, KEY_changed);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (KEY !== 1'b1 || KEY_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_release KEY=%b chg=%b want KEY=1 chg=0", KEY, KEY_changed);
    end
    settle(1'b1, 10);
  endtask

  task automatic test_clean_press();
    KEY_raw = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (KEY !== (e >= 7 ? 1'b0 : 1'b1) || KEY_changed !== (e == 7)) begin
        errors++;
        $display("FAIL clean_press edge %0d KEY=%b chg=%b want KEY=%b chg=%b",
                 e, KEY, KEY_changed, (e >= 7 ? 1'b0 : 1'b1), (e == 7));
      end
    end
    KEY_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (KEY !== (e >= 7 ? 1'b1 : 1'b0) || KEY_changed !== (e == 7)) begin
        errors++;
        $display("FAIL clean_release edge %0d KEY=%b chg=%b want KEY=%b chg=%b",
                 e, KEY, KEY_changed, (e >= 7 ? 1'b1 : 1'b0), (e == 7));
      end
    end
  endtask

  task automatic test_width_boundary();
    // 4 low samples: rejected
    for (int e = 1; e <= 14; e++) begin
      KEY_raw = (e <= 4) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (KEY !== 1'b1 || KEY_changed !== 1'b0) begin
        errors++;
        $display("FAIL width4 edge %0d KEY=%b chg=%b want KEY=1 chg=0", e, KEY, KEY_changed);
      end
    end
    // 5 low samples: accepted at edge 7, release accepted at edge 12
    for (int e = 1; e <= 14; e++) begin
      logic exp_key;
      logic exp_chg;
      KEY_raw = (e <= 5) ? 1'b0 : 1'b1;
      tick();
      exp_key = (e >= 7 && e <= 11) ? 1'b0 : 1'b1;
      exp_chg = (e == 7 || e == 12);
      checks++;
      if (KEY !== exp_key || KEY_changed !== exp_chg) begin
        errors++;
        $display("FAIL width5 edge %0d KEY=%b chg=%b want KEY=%b chg=%b",
                 e, KEY, KEY_changed, exp_key, exp_chg);
      end
    end
    settle(1'b1, 5);
  endtask

  task automatic test_bouncy_release();
    int strobes;
    settle(1'b0, 10);
    checks++;
    if (KEY !== 1'b0) begin
      errors++;
      $display("FAIL bouncy_pre KEY=%b want 0", KEY);
    end
    strobes = 0;
    for (int e = 1; e <= 16; e++) begin
      case (e)
        1, 3:    KEY_raw = 1'b1;
        2, 4:    KEY_raw = 1'b0;
        default: KEY_raw = 1'b1;
      endcase
      tick();
      if (KEY_changed === 1'b1) strobes++;
      checks++;
      if (KEY !== (e >= 11 ? 1'b1 : 1'b0) || KEY_changed !== (e == 11)) begin
        errors++;
        $display("FAIL bouncy edge %0d KEY=%b chg=%b want KEY=%b chg=%b",
                 e, KEY, KEY_changed, (e >= 11 ? 1'b1 : 1'b0), (e == 11));
      end
    end
    checks++;
    if (strobes != 1) begin
      errors++;
      $display("FAIL bouncy_strobes got %0d want 1", strobes);
    end
  endtask

  task automatic test_reset_mid_check();
    KEY_raw = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (KEY !== 1'b1 || KEY_changed !== 1'b0) begin
      errors++;
      $display("FAIL midcheck_rst KEY=%b chg=%b want KEY=1 chg=0", KEY, KEY_changed);
    end
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (KEY !== (e >= 7 ? 1'b0 : 1'b1) || KEY_changed !== (e == 7)) begin
        errors++;
        $display("FAIL midcheck_after edge %0d KEY=%b chg=%b want KEY=%b chg=%b",
                 e, KEY, KEY_changed, (e >= 7 ? 1'b0 : 1'b1), (e == 7));
      end
    end
    // Reset while pressed must force KEY high between edges
    #2 reset = 1'b0;
    #1;
    checks++;
    if (KEY !== 1'b1 || KEY_changed !== 1'b0) begin
      errors++;
      $display("FAIL midpress_rst KEY=%b chg=%b want KEY=1 chg=0", KEY, KEY_changed);
    end
    KEY_raw = 1'b1;
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (KEY !== 1'b1 || KEY_changed !== 1'b0) begin
        errors++;
        $display("FAIL midpress_after edge %0d KEY=%b chg=%b want KEY=1 chg=0",
                 e, KEY, KEY_changed);
      end
    end
  endtask

  task automatic test_long_hold();
    int strobes;
    int first_edge;
    int bad_key;
    strobes    = 0;
    first_edge = -1;
    bad_key    = 0;
    KEY_raw    = 1'b0;
    for (int e = 1; e <= 1000; e++) begin
      tick();
      if (KEY_changed === 1'b1) begin
        strobes++;
        if (first_edge < 0) first_edge = e;
      end
      if (KEY !== (e >= 7 ? 1'b0 : 1'b1)) bad_key++;
    end
    checks++;
    if (strobes != 1) begin
      errors++;
      $display("FAIL long_strobes got %0d want 1", strobes);
    end
    checks++;
    if (first_edge != 7) begin
      errors++;
      $display("FAIL long_strobe_edge got %0d want 7", first_edge);
    end
    checks++;
    if (bad_key != 0) begin
      errors++;
      $display("FAIL long_key_level bad_edges=%0d want 0", bad_key);
    end
    settle(1'b1, 10);
    checks++;
    if (KEY !== 1'b1 || KEY_changed !== 1'b0) begin
      errors++;
      $display("FAIL long_release KEY=%b chg=%b want KEY=1 chg=0", KEY, KEY_changed);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_width_boundary();
    test_bouncy_release();
    settle(1'b1, 10);
    test_reset_mid_check();
    test_long_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
